// File: rtl/sfr_apb_bridge_pkg.sv
// Shared types and constants for the SFR APB bridge and its address decoder.
// State codes are plain localparams so legacy netlists keep matching encodings.
package sfr_apb_bridge_pkg;

  localparam int APB_DATA_W      = 32;
  localparam int CTRL_SFR_OFFSET = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STROBE = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  typedef logic [2:0] lat_cnt_t;

  // Counter preload for the STROBE cycle; WAIT exits when the count reaches 1.
  function automatic lat_cnt_t lat_load(input int resp_latency);
    return lat_cnt_t'(resp_latency - 1);
  endfunction

endpackage

// File: rtl/sfr_apb_addr_decode.sv
// Combinational SFR window decode: hit when paddr is the word-aligned SFR offset.
// With SFR_APB_BRIDGE_PROT_EN, unprivileged writes (pprot[0]==0) decode as a miss.
module sfr_apb_addr_decode
  import sfr_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int OFFSET     = CTRL_SFR_OFFSET
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
`ifdef SFR_APB_BRIDGE_PROT_EN
  input  logic                  pwrite,
  input  logic                  priv,
`endif
  output logic                  hit
);

  logic addr_match;

  assign addr_match = (paddr == ADDR_WIDTH'(OFFSET)) && (paddr[1:0] == 2'b00);

`ifdef SFR_APB_BRIDGE_PROT_EN
  assign hit = addr_match && !(pwrite && !priv);
`else
  assign hit = addr_match;
`endif

endmodule

// File: rtl/sfr_apb_bridge.sv
// APB3 slave front-end turning transfers into single-cycle processor strobes.
// Optional SFR_APB_BRIDGE_PROT_EN adds pprot and rejects unprivileged writes.
module sfr_apb_bridge
  import sfr_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int CTRL_OFFSET  = CTRL_SFR_OFFSET,
  parameter int RESP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
`ifdef SFR_APB_BRIDGE_PROT_EN
  input  logic [2:0]            pprot,
`endif
  output logic                  pready,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pslverr,
  output logic                  write,
  output logic [APB_DATA_W-1:0] write_data,
  output logic                  read,
  input  logic [APB_DATA_W-1:0] read_data,
  input  logic                  error
);

  state_t   state_q;
  lat_cnt_t cnt_q;
  logic     miss_q;
  logic     rd_q;
  logic     setup;
  logic     hit;

  assign setup = psel && !penable;

`ifdef SFR_APB_BRIDGE_PROT_EN
  logic unused_pprot;
  assign unused_pprot = ^pprot[2:1];

  sfr_apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OFFSET     (CTRL_OFFSET)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .priv   (pprot[0]),
    .hit    (hit)
  );
`else
  sfr_apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OFFSET     (CTRL_OFFSET)
  ) u_decode (
    .paddr (paddr),
    .hit   (hit)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      miss_q     <= 1'b0;
      rd_q       <= 1'b0;
      write      <= 1'b0;
      read       <= 1'b0;
      write_data <= '0;
    end else begin
      // Strobes are one-shot: asserted only for the cycle spent in STROBE.
      write <= 1'b0;
      read  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (setup) begin
            rd_q <= !pwrite;
            if (hit) begin
              miss_q  <= 1'b0;
              write   <= pwrite;
              read    <= !pwrite;
              if (pwrite) begin
                write_data <= pwdata;
              end
              state_q <= ST_STROBE;
            end else begin
              miss_q  <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_STROBE: begin
          if (!psel) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= lat_load(RESP_LATENCY);
            state_q <= (RESP_LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (!psel) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == 3'd1) begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Response is sampled straight from the processor during the single RESP cycle.
  always_comb begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    if (state_q == ST_RESP) begin
      pready = 1'b1;
      if (miss_q) begin
        pslverr = 1'b1;
      end else begin
        pslverr = error;
        if (rd_q) begin
          prdata = read_data;
        end
      end
    end
  end

endmodule

// File: doc/sfr_apb_bridge.md
Name: sfr_apb_bridge

Overview:
- APB3 slave front-end directly upstream of the shape processor.
- Converts APB transfers into the processor's single-cycle write/read strobes, write data and response sampling.
- Returns the processor's read_data as PRDATA and its error as PSLVERR.
- Decodes the SFR window; accesses outside it complete with PSLVERR and never reach the processor.

Parameters:
- ADDR_WIDTH, 12, width of paddr.
- CTRL_OFFSET, 0, byte offset of the CTRL SFR; must be word aligned.
- RESP_LATENCY, 1, cycles from strobe to valid processor read_data/error; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  ADDR_WIDTH  APB byte address.
- pwdata  in  32  APB write data.
- pready  out  1  APB ready.
- prdata  out  32  APB read data.
- pslverr  out  1  APB slave error.
- write  out  1  write strobe to processor.
- write_data  out  32  write payload to processor.
- read  out  1  read strobe to processor.
- read_data  in  32  processor read data.
- error  in  1  processor error flag, valid with response.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all outputs 0, FSM in IDLE, latency counter 0.
  - Reset mid-transfer drops the transfer. No strobe is issued after reset release until a new SETUP.
- States: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - On psel && !penable (SETUP), decode paddr.
  - Hit means paddr == CTRL_OFFSET and paddr[1:0] == 0.
  - Hit: register write<=pwrite, read<=!pwrite, write_data<=pwdata (write_data held otherwise); go to STROBE.
  - Miss: set miss flag; go to RESP.
- STROBE:
  - write/read high for exactly this one cycle (the first ACCESS cycle).
  - Load counter with RESP_LATENCY-1.
  - Go to WAIT, or directly to RESP if RESP_LATENCY==1.
- WAIT: decrement counter; at 1 go to RESP.
- RESP:
  - pready=1 for exactly one cycle.
  - Hit: prdata=read_data on reads, 0 on writes; pslverr=error.
  - Miss: prdata=0, pslverr=1.
  - Response outputs are combinational from inputs in RESP only and are 0 in every other state.
  - Next state is IDLE.
- Latency:
  - SETUP at cycle T; strobe in T+1; pready in T+1+RESP_LATENCY.
  - Miss completes with pready in T+1.
- Back-to-back:
  - A new SETUP in the cycle after RESP is accepted.
  - No idle cycle is required beyond APB's own SETUP phase.
- Protocol abuse:
  - psel low in STROBE/WAIT aborts to IDLE with no pready.
  - An already-issued strobe is not retracted.
  - penable high in IDLE without SETUP is ignored.
- write_data changes only on a hit write SETUP. read never coincides with write.

Optional Feature:
- Macro: SFR_APB_BRIDGE_PROT_EN.
- With the macro:
  - Adds input pprot [2:0].
  - A hit write with pprot[0]==0 (unprivileged) is treated as a miss: no write strobe, PSLVERR=1, pready at T+1.
  - Reads are unaffected.
- Without the macro: no pprot port; privilege is not checked.

Decomposition:
- Package sfr_apb_bridge_pkg:
  - state enum (IDLE, STROBE, WAIT, RESP).
  - CTRL_SFR_OFFSET constant.
  - APB_DATA_W=32.
  - Latency counter typedef (3 bits).
- One natural sub-module: sfr_apb_addr_decode.
  - Combinational hit/miss from paddr, plus pprot/pwrite under the macro.
  - Reused by future SFRs.

Test Plan:
- Write 0xA5A5_0001 to offset 0x0 -> write pulse one cycle at T+1, write_data=0xA5A5_0001, pready at T+2, pslverr=0.
- Read offset 0x0 with processor read_data=0x0000_00F3, RESP_LATENCY=3 -> read pulse at T+1, pready at T+4, prdata=0x0000_00F3.
- Write to offset 0x4, then to 0x2 (misaligned) -> no write strobe, pready at T+1, pslverr=1, prdata=0.
- Read with processor error=1 in response cycle -> pslverr=1 with pready; next transfer pslverr=0.
- rst_n low during WAIT of a read -> pready/read/prdata 0 immediately; after release no pready until new SETUP.
- PROT_EN built: write with pprot=3'b000 -> no strobe, pslverr=1; same write with pprot=3'b001 -> strobe, pslverr=0.
